// File: rtl/ret_addr_stack_ckpt.sv
// Return-address stack with circular overwrite, atomic pop+push and
// multi-slot checkpoint/restore for speculative fetch recovery.
module ret_addr_stack_ckpt #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_CKPT   = 4,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CKPT_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop,
  input  logic                  ckpt_save,
  input  logic [CKPT_W-1:0]     ckpt_save_id,
  input  logic                  ckpt_restore,
  input  logic [CKPT_W-1:0]     ckpt_restore_id,
  output logic [ADDR_WIDTH-1:0] ret_addr,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic [CNT_W-1:0]      stack_cnt,
  output logic                  overflow_evt
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      tos;
  logic [CNT_W-1:0]      cnt;

  logic [PTR_W-1:0]      ckpt_tos [NUM_CKPT];
  logic [CNT_W-1:0]      ckpt_cnt [NUM_CKPT];
  logic [ADDR_WIDTH-1:0] ckpt_top [NUM_CKPT];

  logic [PTR_W-1:0]      tos_n;
  logic [CNT_W-1:0]      cnt_n;
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_idx;
  logic [ADDR_WIDTH-1:0] wr_data;
  logic                  ovf_n;
  logic                  full;
  logic                  save_en;

  assign full        = (cnt == CNT_W'(DEPTH));
  assign ret_addr    = mem[tos];
  assign stack_empty = (cnt == '0);
  assign stack_full  = full;
  assign stack_cnt   = cnt;
  assign save_en     = ckpt_save && !ckpt_restore;

  // Next-state selection; restore overrides every other request.
  always_comb begin
    tos_n   = tos;
    cnt_n   = cnt;
    wr_en   = 1'b0;
    wr_idx  = tos;
    wr_data = push_addr;
    ovf_n   = 1'b0;
    if (ckpt_restore) begin
      tos_n   = ckpt_tos[ckpt_restore_id];
      cnt_n   = ckpt_cnt[ckpt_restore_id];
      wr_en   = 1'b1;
      wr_idx  = ckpt_tos[ckpt_restore_id];
      wr_data = ckpt_top[ckpt_restore_id];
    end else if (push && (!pop || cnt == '0)) begin
      tos_n  = tos + PTR_W'(1);
      wr_en  = 1'b1;
      wr_idx = tos + PTR_W'(1);
      cnt_n  = full ? cnt : cnt + CNT_W'(1);
      ovf_n  = full;
    end else if (push && pop) begin
      wr_en = 1'b1;
    end else if (pop && cnt != '0) begin
      tos_n = tos - PTR_W'(1);
      cnt_n = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      tos          <= '0;
      cnt          <= '0;
      overflow_evt <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      for (int i = 0; i < int'(NUM_CKPT); i++) begin
        ckpt_tos[i] <= '0;
        ckpt_cnt[i] <= '0;
        ckpt_top[i] <= '0;
      end
    end else begin
      tos          <= tos_n;
      cnt          <= cnt_n;
      overflow_evt <= ovf_n;
      if (wr_en) mem[wr_idx] <= wr_data;
      // Snapshot uses the pre-update state of this cycle.
      if (save_en) begin
        ckpt_tos[ckpt_save_id] <= tos;
        ckpt_cnt[ckpt_save_id] <= cnt;
        ckpt_top[ckpt_save_id] <= mem[tos];
      end
    end
  end

endmodule
